// File: rtl/io_uart_receiver_pkg.sv
// Shared types and constants for the memory-mapped UART receive port.
// Also holds the STATUS register packing used by the IO decode.
package io_uart_receiver_pkg;

    localparam int SCALAR_WIDTH   = 32;
    localparam int UART_DATA_BITS = 8;

    typedef logic [SCALAR_WIDTH-1:0] scalar_t;

    // STATUS layout: bit 2 frame error, bit 1 overrun, bit 0 data available.
    function automatic scalar_t status_word(input logic frame_err,
                                            input logic overrun,
                                            input logic not_empty);
        return {{(SCALAR_WIDTH-3){1'b0}}, frame_err, overrun, not_empty};
    endfunction

endpackage

// File: rtl/io_uart_receiver_if.sv
// Processor IO read bus as seen by the UART receive port.
// The core drives strobe and address; the peripheral returns registered read data.
interface io_uart_receiver_if;
    import io_uart_receiver_pkg::*;

    logic    io_read_en;
    scalar_t io_address;
    scalar_t io_read_data;

    modport master (
        output io_read_en,
        output io_address,
        input  io_read_data
    );

    modport slave (
        input  io_read_en,
        input  io_address,
        output io_read_data
    );

endinterface

// File: rtl/io_uart_receiver_fifo.sv
// Receive FIFO: circular buffer with registered storage and a combinational head output.
// A pop on an empty buffer is ignored; a push into a full buffer only lands if a pop frees a slot.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[head];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + AW'(1);
            end
            if (do_pop) begin
                head <= head + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/io_uart_receiver.sv
// Memory-mapped 8N1 UART receiver: synchroniser, baud counter, receive FSM and IO read decode.
// Received bytes queue in uart_rx_fifo; STATUS reads clear the sticky error flags.
module io_uart_receiver
    import io_uart_receiver_pkg::*;
#(
    parameter scalar_t BASE_ADDRESS = 'h40,
    parameter int      BAUD_DIVIDE  = 434,
    parameter int      FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    io_uart_receiver_if.slave io
);

    localparam int CW = $clog2(BAUD_DIVIDE);
    localparam int BW = $clog2(UART_DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

    rx_state_t                 state;
    rx_state_t                 state_next;
    logic [CW-1:0]             counter;
    logic [CW-1:0]             counter_next;
    logic [BW-1:0]             bit_idx;
    logic [BW-1:0]             bit_idx_next;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] shift_next;
    logic                      rx_meta;
    logic                      rx_s;
    logic                      tick;
    logic                      push;
    logic                      frame_err_set;
    logic                      overrun_set;
    logic                      overrun;
    logic                      frame_err;
    logic                      status_hit;
    logic                      data_hit;
    logic                      fifo_pop;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [UART_DATA_BITS-1:0] fifo_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            counter <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    assign tick = (counter == '0);

    // The first countdown is half a bit so every later sample lands mid-bit.
    always_comb begin
        state_next    = state;
        counter_next  = counter;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        push          = 1'b0;
        frame_err_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    counter_next = CW'(BAUD_DIVIDE / 2 - 1);
                    state_next   = S_START;
                end
            end
            S_START: begin
                if (!tick) begin
                    counter_next = counter - CW'(1);
                end else if (rx_s) begin
                    state_next = S_IDLE;
                end else begin
                    counter_next = CW'(BAUD_DIVIDE - 1);
                    bit_idx_next = '0;
                    state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    counter_next = counter - CW'(1);
                end else begin
                    shift_next[bit_idx] = rx_s;
                    counter_next        = CW'(BAUD_DIVIDE - 1);
                    if (bit_idx == BW'(UART_DATA_BITS - 1)) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx + BW'(1);
                    end
                end
            end
            S_STOP: begin
                if (!tick) begin
                    counter_next = counter - CW'(1);
                end else if (rx_s) begin
                    push       = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    frame_err_set = 1'b1;
                    state_next    = S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_next),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign status_hit  = io.io_read_en && (io.io_address == BASE_ADDRESS);
    assign data_hit    = io.io_read_en && (io.io_address == BASE_ADDRESS + scalar_t'(4));
    assign fifo_pop    = data_hit && !fifo_empty;
    assign overrun_set = push && fifo_full && !fifo_pop;

    // A flag raised in the same cycle as a STATUS read survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= overrun_set || (overrun && !status_hit);
            frame_err <= frame_err_set || (frame_err && !status_hit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io.io_read_data <= '0;
        end else if (io.io_read_en) begin
            if (status_hit) begin
                io.io_read_data <= status_word(frame_err, overrun, !fifo_empty);
            end else if (data_hit && !fifo_empty) begin
                io.io_read_data <= {{(SCALAR_WIDTH-UART_DATA_BITS){1'b0}}, fifo_head};
            end else begin
                io.io_read_data <= '0;
            end
        end
    end

endmodule
